// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_pkg
// Desc     : Shared AXI4-Lite response codes and FSM state encodings.
// Revision : 1.0 - initial release
// ============================================================================
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/sram_bytewrite.sv
`default_nettype none
// ============================================================================
// Module   : sram_bytewrite
// Desc     : DEPTH x 32 word memory, asynchronous read port and synchronous
//            byte-enable write port. Contents are never cleared.
// Revision : 1.0 - initial release
// ============================================================================
module sram_bytewrite #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [3:0]        i_wstrb,
    input  logic [31:0]       i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_wstrb[i]) begin
                    r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    // A read sampled on the same edge as a commit sees the pre-write word.
    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/axi_lite_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_sram_slave
// Desc     : AXI4-Lite responder backed by a word SRAM; independent read and
//            write paths, each answering after a programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_sram_slave
    import axi_lite_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 4096,
    parameter int          READ_LAT  = 2,
    parameter int          WRITE_LAT = 2,
    parameter int          STRB_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    input  logic [31:0]       awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);

    localparam int          c_addr_w  = $clog2(DEPTH);
    localparam logic [31:0] c_depth   = 32'(DEPTH);
    localparam logic [7:0]  c_rd_init = 8'(READ_LAT - 1);
    localparam logic [7:0]  c_wr_init = 8'(WRITE_LAT - 1);

    rd_state_t   r_rd_state;
    wr_state_t   r_wr_state;
    logic [7:0]  r_rd_cnt;
    logic [7:0]  r_wr_cnt;
    logic [31:0] r_araddr;
    logic [31:0] r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_aw_held;
    logic        r_w_held;

    logic [29:0] w_rd_word;
    logic [29:0] w_wr_word;
    logic        w_rd_ok;
    logic        w_wr_ok;
    logic [31:0] w_sram_rdata;
    logic        w_sram_we;
    logic        w_aw_take;
    logic        w_w_take;
    logic        w_aw_have;
    logic        w_w_have;
    logic        w_unused_strb;

    // Only byte lanes 0..3 exist in a 32-bit word.
    assign w_unused_strb = ^wstrb;

    assign w_rd_word = r_araddr[31:2] - BASE_ADDR[31:2];
    assign w_wr_word = r_awaddr[31:2] - BASE_ADDR[31:2];
    assign w_rd_ok   = (r_araddr >= BASE_ADDR) && ({2'b00, w_rd_word} < c_depth);
    assign w_wr_ok   = (r_awaddr >= BASE_ADDR) && ({2'b00, w_wr_word} < c_depth);

    assign w_sram_we = !rst && (r_wr_state == W_WAIT) && (r_wr_cnt == 8'd0) && w_wr_ok;

    sram_bytewrite #(
        .DEPTH  (DEPTH),
        .ADDR_W (c_addr_w)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_sram_we),
        .i_waddr (w_wr_word[c_addr_w-1:0]),
        .i_wstrb (r_wstrb),
        .i_wdata (r_wdata),
        .i_raddr (w_rd_word[c_addr_w-1:0]),
        .o_rdata (w_sram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_state <= R_IDLE;
            r_rd_cnt   <= 8'd0;
            r_araddr   <= 32'd0;
            arready    <= 1'b0;
            rvalid     <= 1'b0;
            rdata      <= 32'd0;
            rresp      <= RESP_OKAY;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        r_araddr   <= araddr;
                        r_rd_cnt   <= c_rd_init;
                        arready    <= 1'b0;
                        r_rd_state <= R_WAIT;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_WAIT: begin
                    if (r_rd_cnt == 8'd0) begin
                        rvalid     <= 1'b1;
                        rresp      <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
                        rdata      <= w_rd_ok ? w_sram_rdata : 32'd0;
                        r_rd_state <= R_RESP;
                    end else begin
                        r_rd_cnt <= r_rd_cnt - 8'd1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid     <= 1'b0;
                        arready    <= 1'b1;
                        r_rd_state <= R_IDLE;
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    assign w_aw_take = awvalid && awready;
    assign w_w_take  = wvalid && wready;
    assign w_aw_have = r_aw_held || w_aw_take;
    assign w_w_have  = r_w_held || w_w_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_state <= W_IDLE;
            r_wr_cnt   <= 8'd0;
            r_awaddr   <= 32'd0;
            r_wdata    <= 32'd0;
            r_wstrb    <= 4'd0;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            awready    <= 1'b0;
            wready     <= 1'b0;
            bvalid     <= 1'b0;
            bresp      <= RESP_OKAY;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_aw_take) begin
                        r_awaddr <= awaddr;
                    end
                    if (w_w_take) begin
                        r_wdata <= wdata;
                        r_wstrb <= wstrb[3:0];
                    end
                    if (w_aw_have && w_w_have) begin
                        r_aw_held  <= 1'b0;
                        r_w_held   <= 1'b0;
                        awready    <= 1'b0;
                        wready     <= 1'b0;
                        r_wr_cnt   <= c_wr_init;
                        r_wr_state <= W_WAIT;
                    end else begin
                        // Each channel drops its ready once its beat is held.
                        r_aw_held <= w_aw_have;
                        r_w_held  <= w_w_have;
                        awready   <= !w_aw_have;
                        wready    <= !w_w_have;
                    end
                end
                W_WAIT: begin
                    if (r_wr_cnt == 8'd0) begin
                        bvalid     <= 1'b1;
                        bresp      <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
                        r_wr_state <= W_RESP;
                    end else begin
                        r_wr_cnt <= r_wr_cnt - 8'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid     <= 1'b0;
                        awready    <= 1'b1;
                        wready     <= 1'b1;
                        r_wr_state <= W_IDLE;
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_sram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_sram_slave
// Desc     : Directed self-checking bench for axi_lite_sram_slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_sram_slave;

    localparam logic [31:0] BASE      = 32'h8000_0000;
    localparam int          DEPTH     = 4096;
    localparam int          READ_LAT  = 2;
    localparam int          WRITE_LAT = 2;
    localparam logic [31:0] LAST_ADDR = BASE + 32'(4 * (DEPTH - 1));
    localparam logic [31:0] OOR_ADDR  = BASE + 32'(4 * DEPTH);

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [7:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int n_checks = 0;
    int n_errors = 0;

    axi_lite_sram_slave #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .READ_LAT  (READ_LAT),
        .WRITE_LAT (WRITE_LAT),
        .STRB_W    (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".arready"}, 32'(arready), 32'd0);
        check({tag, ".rvalid"},  32'(rvalid),  32'd0);
        check({tag, ".rdata"},   rdata,        32'd0);
        check({tag, ".rresp"},   32'(rresp),   32'd0);
        check({tag, ".awready"}, 32'(awready), 32'd0);
        check({tag, ".wready"},  32'(wready),  32'd0);
        check({tag, ".bvalid"},  32'(bvalid),  32'd0);
        check({tag, ".bresp"},   32'(bresp),   32'd0);
    endtask

    // Called one sample point after the handshake edge that completed AW+W.
    task automatic wait_bresp(input string tag, input logic [1:0] exp_resp);
        repeat (WRITE_LAT) begin
            check({tag, ".bvalid_early"}, 32'(bvalid), 32'd0);
            tick();
        end
        check({tag, ".bvalid"}, 32'(bvalid), 32'd1);
        check({tag, ".bresp"},  32'(bresp),  32'(exp_resp));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check({tag, ".bvalid_clr"}, 32'(bvalid),  32'd0);
        check({tag, ".awready_back"}, 32'(awready), 32'd1);
        check({tag, ".wready_back"},  32'(wready),  32'd1);
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [7:0] s, input logic [1:0] exp_resp);
        check({tag, ".awready"}, 32'(awready), 32'd1);
        check({tag, ".wready"},  32'(wready),  32'd1);
        awaddr = a; awvalid = 1'b1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid = 1'b0;
        check({tag, ".awready_drop"}, 32'(awready), 32'd0);
        check({tag, ".wready_drop"},  32'(wready),  32'd0);
        wait_bresp(tag, exp_resp);
    endtask

    // Called one sample point after the AR handshake edge.
    task automatic wait_rresp(input string tag, input logic [31:0] exp_d,
                              input logic [1:0] exp_r, input int hold);
        repeat (READ_LAT) begin
            check({tag, ".rvalid_early"}, 32'(rvalid), 32'd0);
            tick();
        end
        check({tag, ".rvalid"}, 32'(rvalid), 32'd1);
        check({tag, ".rdata"},  rdata,       exp_d);
        check({tag, ".rresp"},  32'(rresp),  32'(exp_r));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, ".hold_rvalid"},  32'(rvalid),  32'd1);
            check({tag, ".hold_rdata"},   rdata,        exp_d);
            check({tag, ".hold_rresp"},   32'(rresp),   32'(exp_r));
            check({tag, ".hold_arready"}, 32'(arready), 32'd0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check({tag, ".rvalid_clr"},   32'(rvalid),  32'd0);
        check({tag, ".arready_back"}, 32'(arready), 32'd1);
    endtask

    task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                           input logic [1:0] exp_r, input int hold);
        check({tag, ".arready"}, 32'(arready), 32'd1);
        araddr = a; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check({tag, ".arready_drop"}, 32'(arready), 32'd0);
        wait_rresp(tag, exp_d, exp_r, hold);
    endtask

    initial begin
        rst = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;

        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // 1: same-cycle AW/W write, then read back
        do_write("t1_wr", 32'h8000_0010, 32'hDEAD_BEEF, 8'h0F, 2'b00);
        do_read("t1_rd", 32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0);

        // 2: W leads AW by two cycles, partial strobe
        wdata = 32'h1122_3344; wstrb = 8'h05; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("t2_wready_drop", 32'(wready), 32'd0);
        check("t2_awready_on", 32'(awready), 32'd1);
        tick();
        check("t2_wready_low", 32'(wready), 32'd0);
        check("t2_awready_on2", 32'(awready), 32'd1);
        awaddr = 32'h8000_0010; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wait_bresp("t2_wr", 2'b00);
        do_read("t2_rd", 32'h8000_0013, 32'hDE22_BE44, 2'b00, 0);

        // 3: out-of-range accesses on both sides of the window
        do_write("t3_last", LAST_ADDR, 32'hCAFE_F00D, 8'h0F, 2'b00);
        do_read("t3_lo", 32'h7FFF_FFFC, 32'h0, 2'b10, 0);
        do_write("t3_oor_wr", OOR_ADDR, 32'hFFFF_FFFF, 8'h0F, 2'b10);
        do_read("t3_oor_rd", OOR_ADDR, 32'h0, 2'b10, 0);
        do_read("t3_last_rd", LAST_ADDR, 32'hCAFE_F00D, 2'b00, 0);

        // 4: response held while rready is low
        do_read("t4_hold", 32'h8000_0010, 32'hDE22_BE44, 2'b00, 5);

        // 5: read sample coincides with write commit on the same word
        do_write("t5_init", 32'h8000_0020, 32'h0101_0101, 8'h0F, 2'b00);
        araddr = 32'h8000_0020; arvalid = 1'b1;
        awaddr = 32'h8000_0020; awvalid = 1'b1;
        wdata = 32'hA5A5_A5A5; wstrb = 8'h0F; wvalid = 1'b1;
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        repeat (2) begin
            check("t5_rvalid_early", 32'(rvalid), 32'd0);
            check("t5_bvalid_early", 32'(bvalid), 32'd0);
            tick();
        end
        check("t5_rvalid", 32'(rvalid), 32'd1);
        check("t5_rdata_old", rdata, 32'h0101_0101);
        check("t5_bvalid", 32'(bvalid), 32'd1);
        check("t5_bresp", 32'(bresp), 32'd0);
        rready = 1'b1; bready = 1'b1;
        tick();
        rready = 1'b0; bready = 1'b0;
        check("t5_rvalid_clr", 32'(rvalid), 32'd0);
        check("t5_bvalid_clr", 32'(bvalid), 32'd0);
        do_read("t5_new", 32'h8000_0020, 32'hA5A5_A5A5, 2'b00, 0);

        // wstrb with no low-lane bits writes nothing and answers OKAY
        do_write("strb_hi", 32'h8000_0020, 32'h0000_0000, 8'hF0, 2'b00);
        do_read("strb_hi_rd", 32'h8000_0020, 32'hA5A5_A5A5, 2'b00, 0);

        // 6: reset during R_WAIT and W_WAIT
        araddr = 32'h8000_0010; arvalid = 1'b1;
        awaddr = 32'h8000_0020; awvalid = 1'b1;
        wdata = 32'h1234_5678; wstrb = 8'h0F; wvalid = 1'b1;
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        rst = 1'b1;
        tick();
        check_all_zero("t6_rst1");
        tick();
        check_all_zero("t6_rst2");
        rst = 1'b0;
        tick();
        check("t6_arready", 32'(arready), 32'd1);
        check("t6_awready", 32'(awready), 32'd1);
        check("t6_wready", 32'(wready), 32'd1);
        repeat (3) begin
            check("t6_no_rvalid", 32'(rvalid), 32'd0);
            check("t6_no_bvalid", 32'(bvalid), 32'd0);
            tick();
        end
        do_read("t6_discard", 32'h8000_0020, 32'hA5A5_A5A5, 2'b00, 0);
        do_read("t6_fresh", 32'h8000_0010, 32'hDE22_BE44, 2'b00, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
